memory_arbiter: RTL and testbench



---
 rtl/memory_arbiter_if.sv | 54 +++++
 rtl/memory_arbiter.sv | 129 ++++++++++++
 tb/tb_memory_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bus bundle for memory_arbiter: fetch master, load/store master and the shared memory port.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline/memory view.
interface memory_arbiter_if;
    logic [31:0] if_wb_adr_i;
    logic [31:0] if_wb_dat_o;
    logic        if_wb_we_i;
    logic [3:0]  if_wb_sel_i;
    logic        if_wb_stb_i;
    logic        if_wb_cyc_i;
    logic        if_wb_ack_o;
    logic        if_wb_stall_o;

    logic [31:0] ls_wb_adr_i;
    logic [31:0] ls_wb_dat_i;
    logic [31:0] ls_wb_dat_o;
    logic        ls_wb_we_i;
    logic [3:0]  ls_wb_sel_i;
    logic        ls_wb_stb_i;
    logic        ls_wb_cyc_i;
    logic        ls_wb_ack_o;
    logic        ls_wb_stall_o;

    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;
    logic        wb_stall_i;

    logic [1:0]  dbg_state_o;

    modport slave (
        input  if_wb_adr_i, if_wb_we_i, if_wb_sel_i, if_wb_stb_i, if_wb_cyc_i,
        output if_wb_dat_o, if_wb_ack_o, if_wb_stall_o,
        input  ls_wb_adr_i, ls_wb_dat_i, ls_wb_we_i, ls_wb_sel_i, ls_wb_stb_i, ls_wb_cyc_i,
        output ls_wb_dat_o, ls_wb_ack_o, ls_wb_stall_o,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i, wb_stall_i,
        output dbg_state_o
    );

    modport master (
        output if_wb_adr_i, if_wb_we_i, if_wb_sel_i, if_wb_stb_i, if_wb_cyc_i,
        input  if_wb_dat_o, if_wb_ack_o, if_wb_stall_o,
        output ls_wb_adr_i, ls_wb_dat_i, ls_wb_we_i, ls_wb_sel_i, ls_wb_stb_i, ls_wb_cyc_i,
        input  ls_wb_dat_o, ls_wb_ack_o, ls_wb_stall_o,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i, wb_stall_i,
        input  dbg_state_o
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-master pipelined Wishbone arbiter (fetch = master 0, load/store = master 1), zero added latency.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin on collisions; default is load/store priority.
module memory_arbiter (
    input  logic              clk_i,
    input  logic              rst_i,
    memory_arbiter_if.slave   bus
);
    // Handshake: a transfer happens on the rising edge where cyc & stb are high and stall is low;
    // ack returns later while the same cyc is held. Ownership spans a whole cyc.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_LS = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_cyc;
    logic   free_cyc;
    logic   win_if, win_ls;
    logic   act_if, act_ls;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic last_ls_q, last_ls_d;
`endif

    always_comb begin
        owner_cyc = 1'b0;
        case (state_q)
            GRANT_IF: owner_cyc = bus.if_wb_cyc_i;
            GRANT_LS: owner_cyc = bus.ls_wb_cyc_i;
            default:  owner_cyc = 1'b0;
        endcase
        // An unused encoding also counts as free, so the FSM recovers on its own.
        free_cyc = (state_q == IDLE) || !owner_cyc;

        win_if = 1'b0;
        win_ls = 1'b0;
        if (bus.if_wb_cyc_i && bus.ls_wb_cyc_i) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            win_ls = !last_ls_q;
            win_if = last_ls_q;
`else
            win_ls = 1'b1;
`endif
        end else begin
            win_if = bus.if_wb_cyc_i;
            win_ls = bus.ls_wb_cyc_i;
        end

        state_d = state_q;
        act_if  = (state_q == GRANT_IF);
        act_ls  = (state_q == GRANT_LS);
        if (free_cyc) begin
            act_if  = win_if;
            act_ls  = win_ls;
            state_d = win_ls ? GRANT_LS : (win_if ? GRANT_IF : IDLE);
        end
    end

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    always_comb begin
        last_ls_d = last_ls_q;
        if (free_cyc && (win_if || win_ls)) last_ls_d = win_ls;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_ls_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_ls_q <= last_ls_d;
`endif
        end
    end

    always_comb begin
        bus.wb_adr_o      = 32'h0;
        bus.wb_dat_o      = 32'h0;
        bus.wb_we_o       = 1'b0;
        bus.wb_sel_o      = 4'h0;
        bus.wb_stb_o      = 1'b0;
        bus.wb_cyc_o      = 1'b0;
        bus.if_wb_ack_o   = 1'b0;
        bus.ls_wb_ack_o   = 1'b0;
        bus.if_wb_stall_o = bus.wb_stall_i;
        bus.ls_wb_stall_o = bus.wb_stall_i;
        bus.if_wb_dat_o   = bus.wb_dat_i;
        bus.ls_wb_dat_o   = bus.wb_dat_i;
        bus.dbg_state_o   = state_q;

        if (act_ls) begin
            bus.wb_adr_o      = bus.ls_wb_adr_i;
            bus.wb_dat_o      = bus.ls_wb_dat_i;
            bus.wb_we_o       = bus.ls_wb_we_i;
            bus.wb_sel_o      = bus.ls_wb_sel_i;
            bus.wb_stb_o      = bus.ls_wb_stb_i;
            bus.wb_cyc_o      = bus.ls_wb_cyc_i;
            bus.ls_wb_ack_o   = bus.wb_ack_i;
            bus.if_wb_stall_o = 1'b1;
        end else if (act_if) begin
            bus.wb_adr_o      = bus.if_wb_adr_i;
            bus.wb_we_o       = bus.if_wb_we_i;
            bus.wb_sel_o      = bus.if_wb_sel_i;
            bus.wb_stb_o      = bus.if_wb_stb_i;
            bus.wb_cyc_o      = bus.if_wb_cyc_i;
            bus.if_wb_ack_o   = bus.wb_ack_i;
            bus.ls_wb_stall_o = 1'b1;
        end

        // Reset aborts any cycle in flight immediately, not at the next edge.
        if (rst_i) begin
            bus.wb_adr_o      = 32'h0;
            bus.wb_dat_o      = 32'h0;
            bus.wb_we_o       = 1'b0;
            bus.wb_sel_o      = 4'h0;
            bus.wb_stb_o      = 1'b0;
            bus.wb_cyc_o      = 1'b0;
            bus.if_wb_ack_o   = 1'b0;
            bus.ls_wb_ack_o   = 1'b0;
            bus.if_wb_stall_o = 1'b1;
            bus.ls_wb_stall_o = 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios, then randomized traffic checked by a scoreboard
// against a transaction-level model of ownership and a word memory.
`timescale 1ns/1ps
module tb_memory_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_arbiter_if bus();
  memory_arbiter dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic rand_on = 1'b0;

  logic [32:0] exp_if_q[$];
  logic [32:0] exp_ls_q[$];
  logic [68:0] mem_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] mem [16];

  // model of bus ownership: 0 none, 1 fetch, 2 load/store
  int   own;
  logic last_ls;

  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  int          n_iss [2];
  int          outst [2];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.if_wb_adr_i = 32'h0; bus.if_wb_we_i = 1'b0; bus.if_wb_sel_i = 4'hF;
    bus.if_wb_stb_i = 1'b0;  bus.if_wb_cyc_i = 1'b0;
    bus.ls_wb_adr_i = 32'h0; bus.ls_wb_dat_i = 32'h0; bus.ls_wb_we_i = 1'b0;
    bus.ls_wb_sel_i = 4'hF;  bus.ls_wb_stb_i = 1'b0;  bus.ls_wb_cyc_i = 1'b0;
    bus.wb_dat_i = 32'h0; bus.wb_ack_i = 1'b0; bus.wb_stall_i = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor_cycle;
    logic ic, lc, fr;
    int   act;
    logic [37:0] exp_v, got_v;
    logic [68:0] me;
    logic [32:0] e;
    ic = bus.if_wb_cyc_i;
    lc = bus.ls_wb_cyc_i;
    fr = (own == 0) || (own == 1 && !ic) || (own == 2 && !lc);
    act = own;
    if (fr) begin
      if (ic && lc) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        act = last_ls ? 1 : 2;
`else
        act = 2;
`endif
      end else act = lc ? 2 : (ic ? 1 : 0);
      if (act != 0) last_ls = (act == 2);
    end
    own = act;

    case (act)
      1: exp_v = {1'b1, bus.if_wb_stb_i, bus.if_wb_adr_i, bus.wb_ack_i, bus.wb_stall_i, 1'b0, 1'b1};
      2: exp_v = {1'b1, bus.ls_wb_stb_i, bus.ls_wb_adr_i, 1'b0, 1'b1, bus.wb_ack_i, bus.wb_stall_i};
      default: exp_v = {1'b0, 1'b0, 32'h0, 1'b0, bus.wb_stall_i, 1'b0, bus.wb_stall_i};
    endcase
    got_v = {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_adr_o, bus.if_wb_ack_o, bus.if_wb_stall_o,
             bus.ls_wb_ack_o, bus.ls_wb_stall_o};
    chk("route", got_v, exp_v);

    if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_stall_i) begin
      n_cmp++;
      if (mem_q.size() == 0) begin
        n_err++;
        $display("FAIL mem_req: got unexpected request adr %h, required none", bus.wb_adr_o);
      end else begin
        n_cmp--;
        me = mem_q.pop_front();
        chk("mem_req", {bus.wb_adr_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_dat_o}, me);
      end
    end

    if (bus.if_wb_ack_o) begin
      if (exp_if_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL if_ack: got ack, required no ack (nothing outstanding)");
      end else begin
        e = exp_if_q.pop_front();
        if (e[32]) chk("if_rdata", bus.if_wb_dat_o, e[31:0]);
      end
    end
    if (bus.ls_wb_ack_o) begin
      if (exp_ls_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL ls_ack: got ack, required no ack (nothing outstanding)");
      end else begin
        e = exp_ls_q.pop_front();
        if (e[32]) chk("ls_rdata", bus.ls_wb_dat_o, e[31:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (rand_on) monitor_cycle();
  end

  // ---------------- random driver ----------------
  task automatic new_req(input int m);
    m_stb[m] = 1'b1;
    m_adr[m] = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    m_we[m]  = (m == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    m_sel[m] = m_we[m] ? 4'($urandom_range(1, 15)) : 4'hF;
    m_dat[m] = $urandom;
  endtask

  task automatic drive_cycle(input bit start_ok);
    logic        nack, nstall, stl, ak;
    logic [31:0] ndat;
    logic [3:0]  idx;
    logic [32:0] e;
    @(negedge clk);
    nack = 1'b0;
    ndat = $urandom;
    if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_stall_i) begin
      idx  = bus.wb_adr_o[5:2];
      nack = 1'b1;
      if (bus.wb_we_o) begin
        mem[idx] = merge(mem[idx], bus.wb_dat_o, bus.wb_sel_o);
        ndat = 32'h0;
      end else ndat = mem[idx];
    end
    nstall = ($urandom_range(0, 3) == 0);

    for (int m = 0; m < 2; m++) begin
      stl = (m == 1) ? bus.ls_wb_stall_o : bus.if_wb_stall_o;
      ak  = (m == 1) ? bus.ls_wb_ack_o   : bus.if_wb_ack_o;
      if (m_cyc[m] && m_stb[m] && !stl) begin
        mem_q.push_back({m_adr[m], m_we[m], m_sel[m], (m == 1) ? m_dat[m] : 32'h0});
        idx = m_adr[m][5:2];
        if (m_we[m]) begin
          ref_mem[idx] = merge(ref_mem[idx], m_dat[m], m_sel[m]);
          e = {1'b0, 32'h0};
        end else e = {1'b1, ref_mem[idx]};
        if (m == 1) exp_ls_q.push_back(e); else exp_if_q.push_back(e);
        m_stb[m] = 1'b0;
        n_iss[m]--;
        outst[m]++;
      end
      if (ak && outst[m] > 0) outst[m]--;
      if (m_cyc[m]) begin
        if (!m_stb[m] && n_iss[m] > 0 && $urandom_range(0, 2) != 0) new_req(m);
        else if (n_iss[m] == 0 && outst[m] == 0) m_cyc[m] = 1'b0;
      end else if (start_ok && $urandom_range(0, 5) == 0) begin
        m_cyc[m] = 1'b1;
        n_iss[m] = $urandom_range(1, 3);
        outst[m] = 0;
        if ($urandom_range(0, 1) == 1) new_req(m);
      end
    end

    @(posedge clk);
    #1;
    bus.wb_ack_i = nack; bus.wb_dat_i = ndat; bus.wb_stall_i = nstall;
    bus.if_wb_cyc_i = m_cyc[0]; bus.if_wb_stb_i = m_stb[0]; bus.if_wb_adr_i = m_adr[0];
    bus.if_wb_we_i  = m_we[0];  bus.if_wb_sel_i = m_sel[0];
    bus.ls_wb_cyc_i = m_cyc[1]; bus.ls_wb_stb_i = m_stb[1]; bus.ls_wb_adr_i = m_adr[1];
    bus.ls_wb_we_i  = m_we[1];  bus.ls_wb_sel_i = m_sel[1]; bus.ls_wb_dat_i = m_dat[1];
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic exp_ls;
    bit   drained;
    idle_inputs();
    rst = 1'b1;
    bus.if_wb_cyc_i = 1'b1; bus.if_wb_stb_i = 1'b1; bus.if_wb_adr_i = 32'h44;
    bus.ls_wb_cyc_i = 1'b1; bus.ls_wb_stb_i = 1'b1; bus.ls_wb_we_i = 1'b1;
    bus.wb_ack_i = 1'b1;
    tick(); tick();
    chk("reset_gate", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.if_wb_ack_o, bus.ls_wb_ack_o,
                       bus.if_wb_stall_o, bus.ls_wb_stall_o, bus.wb_adr_o}, {7'b0000011, 32'h0});
    chk("reset_state", bus.dbg_state_o, 2'd0);

    // fetch alone
    idle_inputs(); rst = 1'b0;
    bus.if_wb_cyc_i = 1'b1; bus.if_wb_stb_i = 1'b1; bus.if_wb_adr_i = 32'h100;
    #1;
    chk("fetch_req", {bus.wb_adr_o, bus.wb_stb_o, bus.wb_cyc_o, bus.wb_dat_o}, {32'h100, 2'b11, 32'h0});
    tick();
    chk("fetch_state", bus.dbg_state_o, 2'd1);
    bus.if_wb_stb_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEADBEEF;
    #1;
    chk("fetch_ack", {bus.if_wb_ack_o, bus.if_wb_dat_o, bus.ls_wb_ack_o}, {1'b1, 32'hDEADBEEF, 1'b0});
    tick(); idle_inputs(); tick();

    // collision
    bus.if_wb_cyc_i = 1'b1; bus.if_wb_stb_i = 1'b1; bus.if_wb_adr_i = 32'h104;
    bus.ls_wb_cyc_i = 1'b1; bus.ls_wb_stb_i = 1'b1; bus.ls_wb_adr_i = 32'h208;
    #1;
    chk("coll_grant", {bus.if_wb_stall_o, bus.ls_wb_stall_o, bus.wb_adr_o}, {2'b10, 32'h208});
    tick();
    bus.ls_wb_stb_i = 1'b0; bus.wb_ack_i = 1'b1;
    #1;
    chk("coll_hold", {bus.if_wb_stall_o, bus.ls_wb_ack_o, bus.if_wb_ack_o}, 3'b110);
    tick();
    bus.wb_ack_i = 1'b0; bus.ls_wb_cyc_i = 1'b0;
    #1;
    chk("coll_handover", {bus.if_wb_stall_o, bus.wb_adr_o, bus.wb_stb_o}, {1'b0, 32'h104, 1'b1});
    tick(); bus.if_wb_stb_i = 1'b0; bus.wb_ack_i = 1'b1;
    tick(); idle_inputs(); tick();

    // memory stall with a load/store request held off
    bus.if_wb_cyc_i = 1'b1; bus.if_wb_stb_i = 1'b1; bus.if_wb_adr_i = 32'h200;
    bus.wb_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        bus.ls_wb_cyc_i = 1'b1; bus.ls_wb_stb_i = 1'b1; bus.ls_wb_adr_i = 32'h300;
        bus.ls_wb_we_i = 1'b1; bus.ls_wb_sel_i = 4'h3; bus.ls_wb_dat_i = 32'h1234;
      end
      #1;
      chk("mem_stall", {bus.if_wb_stall_o, bus.ls_wb_stall_o, bus.wb_adr_o}, {2'b11, 32'h200});
      tick();
    end
    bus.wb_stall_i = 1'b0;
    #1;
    chk("stall_release", {bus.if_wb_stall_o, bus.ls_wb_stall_o, bus.wb_adr_o}, {2'b01, 32'h200});
    tick();
    bus.if_wb_stb_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hCAFE0001;
    #1;
    chk("stall_ack", {bus.if_wb_ack_o, bus.if_wb_dat_o, bus.ls_wb_ack_o, bus.ls_wb_stall_o},
        {1'b1, 32'hCAFE0001, 2'b01});
    tick();
    bus.wb_ack_i = 1'b0; bus.if_wb_cyc_i = 1'b0;
    #1;
    chk("ls_write", {bus.ls_wb_stall_o, bus.wb_cyc_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_dat_o, bus.wb_adr_o},
        {3'b011, 4'h3, 32'h1234, 32'h300});
    tick();
    bus.ls_wb_stb_i = 1'b0;
    #1;
    chk("ls_state", bus.dbg_state_o, 2'd2);

    // reset while load/store owns the bus
    rst = 1'b1; bus.wb_ack_i = 1'b1;
    #1;
    chk("reset_abort", {bus.wb_cyc_o, bus.ls_wb_ack_o, bus.ls_wb_stall_o}, 3'b001);
    tick();
    rst = 1'b0; idle_inputs();
    bus.if_wb_cyc_i = 1'b1; bus.if_wb_stb_i = 1'b1; bus.if_wb_adr_i = 32'h400;
    #1;
    chk("post_reset", {bus.dbg_state_o, bus.wb_adr_o, bus.wb_stb_o, bus.if_wb_stall_o},
        {2'd0, 32'h400, 2'b10});
    tick(); idle_inputs(); tick();

    // back-to-back simultaneous requests straight after reset
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.if_wb_cyc_i = 1'b1; bus.if_wb_stb_i = 1'b1;
      bus.ls_wb_cyc_i = 1'b1; bus.ls_wb_stb_i = 1'b1;
      #1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      exp_ls = (k % 2 == 0);
`else
      exp_ls = 1'b1;
`endif
      chk("rr_grant", {bus.if_wb_stall_o, bus.ls_wb_stall_o}, exp_ls ? 2'b10 : 2'b01);
      tick(); idle_inputs(); tick();
    end

    // randomized traffic
    rst = 1'b1; tick(); rst = 1'b0; idle_inputs();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      mem[i] = ref_mem[i];
    end
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0; m_sel[m] = 4'hF;
      m_adr[m] = 32'h0; m_dat[m] = 32'h0; n_iss[m] = 0; outst[m] = 0;
    end
    own = 0;
    last_ls = 1'b0;
    rand_on = 1'b1;
    for (int c = 0; c < 4000; c++) drive_cycle(1'b1);
    drained = 1'b0;
    for (int c = 0; c < 300 && !drained; c++) begin
      drive_cycle(1'b0);
      drained = !m_cyc[0] && !m_cyc[1];
    end
    n_cmp++;
    if (!drained) begin
      n_err++;
      $display("FAIL drain_timeout: masters still busy after 300 cycles, required idle");
    end
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    rand_on = 1'b0;
    chk("queues_empty", exp_if_q.size() + exp_ls_q.size() + mem_q.size(), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
